// File: rtl/halut_tree_encoder_ctrl.sv
// Purpose : sequential fp16 decision-tree walker; one level per FETCH/COMPARE pair, returns leaf index.
// Latency : start accepted at edge k -> valid_o high from cycle k+2*TreeDepth; one encoding per 2*TreeDepth+2 cycles.
// Backpr. : in DONE, valid_o/idx_o hold until ready_i; start_i is ignored whenever busy_o is high.
//
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   cfg_we_i/cfg_addr_i/thr/dim       node-table write port (heap order, honoured only in IDLE)
//   start_i, busy_o                   request one encoding / controller not idle
//   feat_req_o/feat_addr_o/feat_data_i feature buffer read (data returns one cycle after the request)
//   valid_o, idx_o, ready_i           leaf index handshake

module fp_16_comparision (
  input  logic [15:0] operand_a_i,
  input  logic [15:0] operand_b_i,
  output logic        gt_o
);
  // Strict a > b on sign-magnitude fp16; NaN/Inf are plain bit patterns.
  always_comb begin
    gt_o = 1'b0;
    case ({operand_a_i[15], operand_b_i[15]})
      2'b00:   gt_o = operand_a_i[14:0] > operand_b_i[14:0];
      2'b01:   gt_o = 1'b1;  // positive beats negative, so +0 > -0
      2'b10:   gt_o = 1'b0;
      default: gt_o = operand_a_i[14:0] < operand_b_i[14:0];  // both negative: smaller magnitude wins
    endcase
  end
endmodule

module halut_tree_encoder_ctrl #(
  parameter int TreeDepth = 4,
  parameter int DimWidth  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_we_i,
  input  logic [TreeDepth-1:0] cfg_addr_i,
  input  logic [15:0]          cfg_thr_i,
  input  logic [DimWidth-1:0]  cfg_dim_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 feat_req_o,
  output logic [DimWidth-1:0]  feat_addr_o,
  input  logic [15:0]          feat_data_i,
  output logic                 valid_o,
  output logic [TreeDepth-1:0] idx_o,
  input  logic                 ready_i
);
  localparam int NumNodes = (1 << TreeDepth) - 1;
  localparam int LvlW     = (TreeDepth > 1) ? $clog2(TreeDepth) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] COMPARE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]           state_q;
  logic [TreeDepth-1:0] node_q;
  logic [LvlW-1:0]      level_q;
  logic [TreeDepth-1:0] idx_q;
  logic [DimWidth-1:0]  addr_q;
  logic [15:0]          thr_q [NumNodes];
  logic [DimWidth-1:0]  dim_q [NumNodes];
  logic                 gt;

  fp_16_comparision u_cmp (
    .operand_a_i (feat_data_i),
    .operand_b_i (thr_q[node_q]),
    .gt_o        (gt)
  );

  // Node table: all-ones address is outside the 2^TreeDepth-1 entry table, so it is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumNodes; i++) begin
        thr_q[i] <= '0;
        dim_q[i] <= '0;
      end
    end else if (state_q == IDLE && cfg_we_i && cfg_addr_i != '1) begin
      thr_q[cfg_addr_i] <= cfg_thr_i;
      dim_q[cfg_addr_i] <= cfg_dim_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      node_q  <= '0;
      level_q <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= FETCH;
            node_q  <= '0;
            level_q <= '0;
            idx_q   <= '0;
          end
        end
        FETCH: begin
          addr_q  <= dim_q[node_q];
          state_q <= COMPARE;
        end
        COMPARE: begin
          idx_q <= (idx_q << 1) | TreeDepth'(gt);
          // Heap child: 2n+1 (left) or 2n+2 (right). The wrap on the last
          // level is harmless because the node is not read again.
          node_q <= (node_q << 1) + TreeDepth'(1) + TreeDepth'(gt);
          if (level_q == LvlW'(TreeDepth - 1)) begin
            state_q <= DONE;
          end else begin
            level_q <= level_q + LvlW'(1);
            state_q <= FETCH;
          end
        end
        default: begin
          if (ready_i) state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign feat_req_o  = (state_q == FETCH);
  // Address is live in FETCH and then parked on the last fetched dimension.
  assign feat_addr_o = feat_req_o ? dim_q[node_q] : addr_q;
  assign valid_o     = (state_q == DONE);
  assign idx_o       = idx_q;

endmodule

// File: tb/tb_halut_tree_encoder_ctrl.sv
module tb_halut_tree_encoder_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] cfg_thr;
  logic [4:0]  cfg_dim;

  logic        d2_cfg_we, d2_start, d2_busy, d2_req, d2_valid, d2_ready;
  logic [1:0]  d2_cfg_addr, d2_idx;
  logic [4:0]  d2_addr;
  logic [15:0] d2_fdata;

  logic        d4_cfg_we, d4_start, d4_busy, d4_req, d4_valid, d4_ready;
  logic [3:0]  d4_cfg_addr, d4_idx;
  logic [4:0]  d4_addr;
  logic [15:0] d4_fdata;

  halut_tree_encoder_ctrl #(.TreeDepth(2), .DimWidth(5)) u_d2 (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(d2_cfg_we), .cfg_addr_i(d2_cfg_addr),
    .cfg_thr_i(cfg_thr), .cfg_dim_i(cfg_dim), .start_i(d2_start), .busy_o(d2_busy),
    .feat_req_o(d2_req), .feat_addr_o(d2_addr), .feat_data_i(d2_fdata),
    .valid_o(d2_valid), .idx_o(d2_idx), .ready_i(d2_ready)
  );

  halut_tree_encoder_ctrl #(.TreeDepth(4), .DimWidth(5)) u_d4 (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(d4_cfg_we), .cfg_addr_i(d4_cfg_addr),
    .cfg_thr_i(cfg_thr), .cfg_dim_i(cfg_dim), .start_i(d4_start), .busy_o(d4_busy),
    .feat_req_o(d4_req), .feat_addr_o(d4_addr), .feat_data_i(d4_fdata),
    .valid_o(d4_valid), .idx_o(d4_idx), .ready_i(d4_ready)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_addr_q[$];

  logic [15:0] feat_mem [32];
  logic [15:0] m_thr [4];
  logic [4:0]  m_dim [4];

  // Feature buffer: data answers one cycle after the request.
  always @(posedge clk) begin
    if (d2_req) d2_fdata <= feat_mem[d2_addr];
    if (d4_req) d4_fdata <= feat_mem[d4_addr];
  end

  // Monotonic ordering key for sign-magnitude fp16.
  function automatic logic [15:0] ord_key(input logic [15:0] x);
    return x[15] ? ~x : (x ^ 16'h8000);
  endfunction

  task automatic model2(output int idx);
    int n;
    logic [4:0] a;
    n = 0;
    for (int l = 0; l < 2; l++) begin
      a = m_dim[n];
      exp_addr_q.push_back(int'(a));
      if (ord_key(feat_mem[a]) > ord_key(m_thr[n])) n = 2 * n + 2;
      else n = 2 * n + 1;
    end
    idx = n - 3;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      m_thr[i] = '0;
      m_dim[i] = '0;
    end
  endtask

  task automatic cfg2(input int addr, input logic [15:0] thr, input logic [4:0] dim, input bit apply);
    d2_cfg_we = 1'b1; d2_cfg_addr = addr[1:0]; cfg_thr = thr; cfg_dim = dim;
    @(negedge clk);
    d2_cfg_we = 1'b0;
    if (apply) begin
      m_thr[addr] = thr;
      m_dim[addr] = dim;
    end
  endtask

  // One encoding on the depth-2 instance; called and returns at a negedge.
  task automatic run2(input int hold, input bit bad_write, output logic [1:0] got);
    int e, a, cyc;
    logic [1:0] held;
    model2(e);
    exp_q.push_back(e);
    d2_start = 1'b1;
    @(negedge clk);
    d2_start = 1'b0;
    cyc = 1;
    if (bad_write) begin
      d2_cfg_we = 1'b1; d2_cfg_addr = 2'd0; cfg_thr = 16'h7BFF; cfg_dim = 5'd7;
    end
    while (!d2_valid && cyc < 40) begin
      if (d2_req) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL feat_addr: unexpected fetch of addr %0d, required none", d2_addr);
        end else begin
          a = exp_addr_q.pop_front();
          if (d2_addr !== 5'(a)) begin
            errors++;
            $display("FAIL feat_addr: got %0d required %0d", d2_addr, a);
          end
        end
      end
      @(negedge clk);
      cyc++;
      d2_cfg_we = 1'b0;
    end
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL latency: valid after %0d cycles required 5", cyc);
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL fetch_count: %0d fetches missing, required 0", exp_addr_q.size());
      exp_addr_q.delete();
    end
    e = exp_q.pop_front();
    got = d2_idx;
    if (!d2_valid) return;
    checks++;
    if (d2_idx !== 2'(e)) begin
      errors++;
      $display("FAIL idx_d2: got %0d required %0d", d2_idx, e);
    end
    held = d2_idx;
    for (int i = 0; i < hold; i++) begin
      d2_start = 1'b1;
      @(negedge clk);
      d2_start = 1'b0;
      checks++;
      if (d2_valid !== 1'b1 || d2_idx !== held || d2_busy !== 1'b1) begin
        errors++;
        $display("FAIL hold: valid=%0b idx=%0d busy=%0b required 1/%0d/1", d2_valid, d2_idx, d2_busy, held);
      end
    end
    d2_ready = 1'b1;
    @(negedge clk);
    d2_ready = 1'b0;
    checks++;
    if (d2_valid !== 1'b0 || d2_busy !== 1'b0) begin
      errors++;
      $display("FAIL release: valid=%0b busy=%0b required 0/0", d2_valid, d2_busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (d2_busy !== 0 || d2_valid !== 0 || d2_idx !== 0 || d2_req !== 0 || d2_addr !== 0) begin
      errors++;
      $display("FAIL reset_d2: busy=%0b valid=%0b idx=%0d req=%0b addr=%0d required all 0",
               d2_busy, d2_valid, d2_idx, d2_req, d2_addr);
    end
    checks++;
    if (d4_busy !== 0 || d4_valid !== 0 || d4_idx !== 0 || d4_req !== 0 || d4_addr !== 0) begin
      errors++;
      $display("FAIL reset_d4: busy=%0b valid=%0b idx=%0d req=%0b addr=%0d required all 0",
               d4_busy, d4_valid, d4_idx, d4_req, d4_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (d2_busy !== 0 || d2_valid !== 0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%0b valid=%0b required 0/0", d2_busy, d2_valid);
    end
  endtask

  task automatic test_reset_midrun();
    logic [1:0] got;
    cfg2(0, 16'h0000, 5'd0, 1);
    feat_mem[0] = 16'h3C00;
    d2_start = 1'b1;
    @(negedge clk);
    d2_start = 1'b0;
    repeat (3) @(negedge clk);  // now in the second COMPARE
    checks++;
    if (d2_idx !== 2'd1 || d2_busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_idx: idx=%0d busy=%0b required 1/1", d2_idx, d2_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (d2_busy !== 0 || d2_valid !== 0 || d2_idx !== 0 || d2_req !== 0) begin
      errors++;
      $display("FAIL async_reset: busy=%0b valid=%0b idx=%0d req=%0b required 0", d2_busy, d2_valid, d2_idx, d2_req);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    run2(0, 0, got);
    checks++;
    if (got !== 2'd3) begin
      errors++;
      $display("FAIL zero_table: idx=%0d required 3", got);
    end
  endtask

  task automatic test_walk();
    logic [1:0] got;
    cfg2(0, 16'h3C00, 5'd0, 1);
    cfg2(1, 16'h3800, 5'd1, 1);
    cfg2(2, 16'hBC00, 5'd2, 1);
    feat_mem[0] = 16'h4000; feat_mem[1] = 16'h3000; feat_mem[2] = 16'hBC00;
    run2(0, 0, got);
    checks++;
    if (got !== 2'd2) begin
      errors++;
      $display("FAIL walk: idx=%0d required 2", got);
    end
  endtask

  task automatic test_negative();
    logic [1:0] got;
    cfg2(0, 16'hC000, 5'd0, 1);
    feat_mem[0] = 16'hBC00;
    run2(0, 0, got);
    checks++;
    if (got[1] !== 1'b1) begin
      errors++;
      $display("FAIL neg_right: decision=%0b required 1", got[1]);
    end
    feat_mem[0] = 16'hC200;
    run2(0, 0, got);
    checks++;
    if (got[1] !== 1'b0) begin
      errors++;
      $display("FAIL neg_left: decision=%0b required 0", got[1]);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] got;
    feat_mem[0] = 16'h4000;
    run2(5, 0, got);
  endtask

  task automatic test_cfg_gating();
    logic [1:0] got;
    feat_mem[7] = 16'h0000;
    run2(0, 1, got);
    cfg2(3, 16'h0000, 5'd9, 0);
    run2(0, 0, got);
    checks++;
    if (got !== 2'd2) begin
      errors++;
      $display("FAIL cfg_gating: idx=%0d required 2", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] got;
    feat_mem[0] = 16'hC200;
    run2(0, 0, got);
    feat_mem[0] = 16'h4000;
    run2(0, 0, got);
  endtask

  task automatic test_signed_zero_d4();
    int cyc, e;
    for (int i = 0; i < 15; i++) begin
      d4_cfg_we = 1'b1; d4_cfg_addr = 4'(i); cfg_thr = 16'h8000; cfg_dim = 5'(i);
      feat_mem[i] = 16'h0000;
      @(negedge clk);
    end
    d4_cfg_we = 1'b0;
    exp_q.push_back(15);
    d4_start = 1'b1;
    @(negedge clk);
    d4_start = 1'b0;
    cyc = 1;
    while (!d4_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 9) begin
      errors++;
      $display("FAIL latency_d4: valid after %0d cycles required 9", cyc);
    end
    e = exp_q.pop_front();
    checks++;
    if (d4_idx !== 4'(e)) begin
      errors++;
      $display("FAIL idx_d4: got %0d required %0d", d4_idx, e);
    end
    d4_ready = 1'b1;
    @(negedge clk);
    d4_ready = 1'b0;
    checks++;
    if (d4_valid !== 1'b0 || d4_busy !== 1'b0) begin
      errors++;
      $display("FAIL release_d4: valid=%0b busy=%0b required 0/0", d4_valid, d4_busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_thr = '0; cfg_dim = '0;
    d2_cfg_we = 0; d2_cfg_addr = '0; d2_start = 0; d2_ready = 0;
    d4_cfg_we = 0; d4_cfg_addr = '0; d4_start = 0; d4_ready = 0;
    for (int i = 0; i < 32; i++) feat_mem[i] = 16'h0000;
    clear_model();
    repeat (2) @(negedge clk);
    test_reset();
    test_reset_midrun();
    test_walk();
    test_negative();
    test_backpressure();
    test_cfg_gating();
    test_back_to_back();
    test_signed_zero_d4();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d results never produced, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
